// File: rtl/mem_stage_fwd_unit_if.sv
// Pipeline-side signal bundle for mem_stage_fwd_unit: X/M instructions, M write-back
// value and the forwarding/stall results returned to the DMEM address/data muxes.
interface mem_stage_fwd_unit_if #(
  parameter int XLEN = 32
);
  logic            advance;
  logic [31:0]     inst_X;
  logic [31:0]     inst_M;
  logic [XLEN-1:0] wb_data_M;
  logic [1:0]      addr_fwd_sel;
  logic [1:0]      data_fwd_sel;
  logic [XLEN-1:0] fwd_addr;
  logic [XLEN-1:0] fwd_data;
  logic            hazard_stall;

  modport master (
    output advance, inst_X, inst_M, wb_data_M,
    input  addr_fwd_sel, data_fwd_sel, fwd_addr, fwd_data, hazard_stall
  );

  modport slave (
    input  advance, inst_X, inst_M, wb_data_M,
    output addr_fwd_sel, data_fwd_sel, fwd_addr, fwd_data, hazard_stall
  );
endinterface

// File: rtl/mem_stage_fwd_unit.sv
// M-stage/history operand forwarding for the store in X, with load-latency stall tracking.
// Optional FWD_LOAD_ADDR_EN: a LOAD in X also consumes forwarded rs1 (load-to-load address chain).
module mem_stage_fwd_unit #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_stage_fwd_unit_if.slave bus
);
  localparam int CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:                      writes_rd = 1'b0;
    endcase
  endfunction

  logic [6:0] opc_x, opc_m;
  logic [4:0] rs1_x, rs2_x, rd_m;
  logic       writer_m, load_m, store_x, load_x;
  logic       addr_cons, data_cons;

  assign opc_x = bus.inst_X[6:0];
  assign rs1_x = bus.inst_X[19:15];
  assign rs2_x = bus.inst_X[24:20];
  assign opc_m = bus.inst_M[6:0];
  assign rd_m  = bus.inst_M[11:7];

  assign writer_m = writes_rd(opc_m) && (rd_m != 5'd0);
  assign load_m   = (opc_m == OPC_LOAD);
  assign store_x  = (opc_x == OPC_STORE);
  assign load_x   = (opc_x == OPC_LOAD);

`ifdef FWD_LOAD_ADDR_EN
  assign addr_cons = store_x || load_x;
`else
  assign addr_cons = store_x;
`endif
  assign data_cons = store_x;

  logic unused_inst_bits;
  assign unused_inst_bits = ^{bus.inst_X[31:25], bus.inst_X[14:7], bus.inst_M[31:12]};

  // Retired write-back history, index 0 youngest
  logic [DEPTH-1:0]           hist_valid_q, hist_valid_d;
  logic [DEPTH-1:0][4:0]      hist_rd_q, hist_rd_d;
  logic [DEPTH-1:0][XLEN-1:0] hist_data_q, hist_data_d;

  always_comb begin
    hist_valid_d = hist_valid_q;
    hist_rd_d    = hist_rd_q;
    hist_data_d  = hist_data_q;
    if (bus.advance) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        hist_valid_d[i] = hist_valid_q[i-1];
        hist_rd_d[i]    = hist_rd_q[i-1];
        hist_data_d[i]  = hist_data_q[i-1];
      end
      // A non-writer in M still occupies a slot so entries keep their age order
      hist_valid_d[0] = writer_m;
      hist_rd_d[0]    = rd_m;
      hist_data_d[0]  = bus.wb_data_M;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_valid_q <= '0;
    end else begin
      hist_valid_q <= hist_valid_d;
      hist_rd_q    <= hist_rd_d;
      hist_data_q  <= hist_data_d;
    end
  end

  // Load latency counter; stays at zero when LOAD_LAT is zero
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.advance && load_x) begin
      cnt_d = CNT_W'(LOAD_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pending = (cnt_q != '0);

  logic [DEPTH-1:0] hit_rs1, hit_rs2;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign hit_rs1[gi] = hist_valid_q[gi] && (hist_rd_q[gi] == rs1_x);
    assign hit_rs2[gi] = hist_valid_q[gi] && (hist_rd_q[gi] == rs2_x);
  end

  logic [XLEN-1:0] hist_rs1_val, hist_rs2_val;

  always_comb begin
    hist_rs1_val = '0;
    hist_rs2_val = '0;
    // Walk oldest to youngest so the youngest matching entry wins
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_rs1[i]) hist_rs1_val = hist_data_q[i];
      if (hit_rs2[i]) hist_rs2_val = hist_data_q[i];
    end
  end

  logic [1:0]      addr_sel, data_sel;
  logic [XLEN-1:0] addr_val, data_val;
  logic            stall;

  always_comb begin
    addr_sel = 2'd0;
    addr_val = '0;
    data_sel = 2'd0;
    data_val = '0;
    if (addr_cons && rs1_x != 5'd0) begin
      if (writer_m && rd_m == rs1_x) begin
        addr_sel = 2'd1;
        addr_val = bus.wb_data_M;
      end else if (|hit_rs1) begin
        addr_sel = 2'd2;
        addr_val = hist_rs1_val;
      end
    end
    if (data_cons && rs2_x != 5'd0) begin
      if (writer_m && rd_m == rs2_x) begin
        data_sel = 2'd1;
        data_val = bus.wb_data_M;
      end else if (|hit_rs2) begin
        data_sel = 2'd2;
        data_val = hist_rs2_val;
      end
    end
    stall = load_m && pending && (addr_sel == 2'd1 || data_sel == 2'd1);
  end

  always_comb begin
    bus.addr_fwd_sel = 2'd0;
    bus.data_fwd_sel = 2'd0;
    bus.fwd_addr     = '0;
    bus.fwd_data     = '0;
    bus.hazard_stall = 1'b0;
    if (rst_n) begin
      bus.addr_fwd_sel = addr_sel;
      bus.data_fwd_sel = data_sel;
      bus.fwd_addr     = addr_val;
      bus.fwd_data     = data_val;
      bus.hazard_stall = stall;
    end
  end
endmodule

// File: tb/tb_mem_stage_fwd_unit.sv
// Directed bench for mem_stage_fwd_unit: a LOAD_LAT=2 unit checked from a vector table and
// hand sequences, plus a LOAD_LAT=0 unit fed the same stimulus.
module tb_mem_stage_fwd_unit;
  localparam int XLEN = 32;
`ifdef FWD_LOAD_ADDR_EN
  localparam bit LDF = 1'b1;
`else
  localparam bit LDF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_stage_fwd_unit_if #(.XLEN(XLEN)) bus ();
  mem_stage_fwd_unit_if #(.XLEN(XLEN)) bus0 ();

  assign bus0.advance   = bus.advance;
  assign bus0.inst_X    = bus.inst_X;
  assign bus0.inst_M    = bus.inst_M;
  assign bus0.wb_data_M = bus.wb_data_M;

  mem_stage_fwd_unit #(.XLEN(XLEN), .DEPTH(2), .LOAD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  mem_stage_fwd_unit #(.XLEN(XLEN), .DEPTH(2), .LOAD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] jal(input logic [4:0] rd);
    return {20'h00000, rd, 7'b1101111};
  endfunction

  typedef struct {
    logic        adv;
    logic [31:0] ix;
    logic [31:0] im;
    logic [31:0] wb;
    logic [1:0]  es_a;
    logic [1:0]  es_d;
    logic [31:0] ea;
    logic [31:0] ed;
    logic        est;
  } vec_t;

  function automatic vec_t mkv(input logic adv, input logic [31:0] ix, input logic [31:0] im,
                               input logic [31:0] wb, input logic [1:0] es_a, input logic [31:0] ea,
                               input logic [1:0] es_d, input logic [31:0] ed);
    vec_t v;
    v.adv = adv; v.ix = ix; v.im = im; v.wb = wb;
    v.es_a = es_a; v.ea = ea; v.es_d = es_d; v.ed = ed; v.est = 1'b0;
    return v;
  endfunction

  task automatic drive(input logic adv, input logic [31:0] ix, input logic [31:0] im,
                       input logic [31:0] wb);
    bus.advance   = adv;
    bus.inst_X    = ix;
    bus.inst_M    = im;
    bus.wb_data_M = wb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[13];
  logic [31:0] nop;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nop = addi(5'd0, 5'd0, 12'h000);

    vt[0]  = mkv(1, nop,                    addi(5'd6, 5'd0, 12'h0AB), 32'hAB,       0, 0,           0, 0);
    vt[1]  = mkv(1, sw(5'd6, 5'd2, 12'd4),  addi(5'd9, 5'd0, 12'h055), 32'h55,       0, 0,           2, 32'hAB);
    vt[2]  = mkv(1, sw(5'd9, 5'd6, 12'd0),  addi(5'd3, 5'd0, 12'h011), 32'h11,       2, 32'hAB,      2, 32'h55);
    vt[3]  = mkv(1, nop,                    addi(5'd3, 5'd0, 12'h022), 32'h22,       0, 0,           0, 0);
    vt[4]  = mkv(0, sw(5'd3, 5'd3, 12'd0),  addi(5'd0, 5'd0, 12'h099), 32'h99,       2, 32'h22,      2, 32'h22);
    vt[5]  = mkv(1, sw(5'd3, 5'd3, 12'd0),  addi(5'd3, 5'd0, 12'h077), 32'h77,       1, 32'h77,      1, 32'h77);
    vt[6]  = mkv(1, sw(5'd0, 5'd0, 12'd0),  addi(5'd0, 5'd0, 12'h099), 32'h99,       0, 0,           0, 0);
    vt[7]  = mkv(1, sw(5'd3, 5'd5, 12'd0),  sw(5'd1, 5'd2, 12'd3),     32'h66,       0, 0,           2, 32'h77);
    vt[8]  = mkv(1, sw(5'd3, 5'd3, 12'd0),  nop,                       32'h0,        0, 0,           0, 0);
    vt[9]  = mkv(1, sw(5'd4, 5'd7, 12'd0),  lui(5'd7, 20'h12345),      32'h12345000, 1, 32'h12345000, 0, 0);
    vt[10] = mkv(1, lw(5'd8, 5'd7),         nop,                       32'h0,
                 LDF ? 2'd2 : 2'd0, LDF ? 32'h12345000 : 32'h0, 0, 0);
    vt[11] = mkv(1, nop,                    jal(5'd1),                 32'h40,       0, 0,           0, 0);
    vt[12] = mkv(1, sw(5'd1, 5'd1, 12'd0),  nop,                       32'h0,        2, 32'h40,      2, 32'h40);

    // Reset: outputs held at zero even with a forwardable pair present
    rst_n = 1'b0;
    drive(1, sw(5'd6, 5'd6, 12'd0), addi(5'd6, 5'd0, 12'h0AB), 32'hAB);
    @(negedge clk);
    chk("rst_addr_sel", 32'(bus.addr_fwd_sel), 0);
    chk("rst_data_sel", 32'(bus.data_fwd_sel), 0);
    chk("rst_fwd_addr", bus.fwd_addr, 0);
    chk("rst_fwd_data", bus.fwd_data, 0);
    chk("rst_stall", 32'(bus.hazard_stall), 0);
    $display("txn reset sel_a=%0d sel_d=%0d", bus.addr_fwd_sel, bus.data_fwd_sel);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].adv, vt[i].ix, vt[i].im, vt[i].wb);
      @(negedge clk);
      $display("txn vec%0d X=%08h M=%08h sel_a=%0d a=%08h sel_d=%0d d=%08h stall=%0d",
               i, vt[i].ix, vt[i].im, bus.addr_fwd_sel, bus.fwd_addr,
               bus.data_fwd_sel, bus.fwd_data, bus.hazard_stall);
      chk($sformatf("vec%0d_addr_sel", i), 32'(bus.addr_fwd_sel), 32'(vt[i].es_a));
      chk($sformatf("vec%0d_fwd_addr", i), bus.fwd_addr, vt[i].ea);
      chk($sformatf("vec%0d_data_sel", i), 32'(bus.data_fwd_sel), 32'(vt[i].es_d));
      chk($sformatf("vec%0d_fwd_data", i), bus.fwd_data, vt[i].ed);
      chk($sformatf("vec%0d_stall", i), 32'(bus.hazard_stall), 32'(vt[i].est));
      next_cycle();
    end

    // LOAD_LAT=0: load result forwarded from M immediately, no stall
    drive(0, sw(5'd6, 5'd5, 12'd0), lw(5'd5, 5'd1), 32'h2000);
    @(negedge clk);
    $display("txn lat0 sel_a=%0d a=%08h stall=%0d", bus0.addr_fwd_sel, bus0.fwd_addr, bus0.hazard_stall);
    chk("lat0_addr_sel", 32'(bus0.addr_fwd_sel), 1);
    chk("lat0_fwd_addr", bus0.fwd_addr, 32'h2000);
    chk("lat0_data_sel", 32'(bus0.data_fwd_sel), 0);
    chk("lat0_stall", 32'(bus0.hazard_stall), 0);
    next_cycle();

    // LOAD_LAT=2: two stall cycles, then the load value forwards
    drive(1, lw(5'd5, 5'd1), nop, 32'h0);
    next_cycle();
    drive(0, sw(5'd7, 5'd5, 12'd0), lw(5'd5, 5'd1), 32'hDEAD);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      $display("txn lat2 stall cycle%0d stall=%0d sel_a=%0d", c, bus.hazard_stall, bus.addr_fwd_sel);
      chk($sformatf("lat2_stall_c%0d", c), 32'(bus.hazard_stall), 1);
      chk($sformatf("lat2_sel_c%0d", c), 32'(bus.addr_fwd_sel), 1);
      chk($sformatf("lat0_nostall_c%0d", c), 32'(bus0.hazard_stall), 0);
      next_cycle();
    end
    bus.wb_data_M = 32'h1000;
    @(negedge clk);
    $display("txn lat2 release stall=%0d a=%08h", bus.hazard_stall, bus.fwd_addr);
    chk("lat2_release_stall", 32'(bus.hazard_stall), 0);
    chk("lat2_release_sel", 32'(bus.addr_fwd_sel), 1);
    chk("lat2_release_addr", bus.fwd_addr, 32'h1000);
    chk("lat2_release_data_sel", 32'(bus.data_fwd_sel), 0);
    next_cycle();

    // Reset in the middle of a data-operand stall
    drive(1, lw(5'd5, 5'd1), addi(5'd6, 5'd0, 12'h066), 32'h66);
    next_cycle();
    drive(0, sw(5'd5, 5'd6, 12'd0), lw(5'd5, 5'd1), 32'hDEAD);
    @(negedge clk);
    $display("txn prereset stall=%0d sel_a=%0d sel_d=%0d", bus.hazard_stall, bus.addr_fwd_sel, bus.data_fwd_sel);
    chk("pre_rst_stall", 32'(bus.hazard_stall), 1);
    chk("pre_rst_data_sel", 32'(bus.data_fwd_sel), 1);
    chk("pre_rst_fwd_data", bus.fwd_data, 32'hDEAD);
    chk("pre_rst_addr_sel", 32'(bus.addr_fwd_sel), 2);
    chk("pre_rst_fwd_addr", bus.fwd_addr, 32'h66);
    rst_n = 1'b0;
    #1;
    chk("in_rst_stall", 32'(bus.hazard_stall), 0);
    chk("in_rst_data_sel", 32'(bus.data_fwd_sel), 0);
    chk("in_rst_fwd_addr", bus.fwd_addr, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    $display("txn postreset stall=%0d sel_a=%0d sel_d=%0d", bus.hazard_stall, bus.addr_fwd_sel, bus.data_fwd_sel);
    chk("post_rst_stall", 32'(bus.hazard_stall), 0);
    chk("post_rst_addr_sel", 32'(bus.addr_fwd_sel), 0);
    chk("post_rst_data_sel", 32'(bus.data_fwd_sel), 1);
    chk("post_rst_fwd_data", bus.fwd_data, 32'hDEAD);
    next_cycle();

    // Load-to-load address chain behind a load in M
    drive(0, lw(5'd8, 5'd5), lw(5'd5, 5'd1), 32'h3000);
    @(negedge clk);
    $display("txn ldld sel_a=%0d a=%08h", bus0.addr_fwd_sel, bus0.fwd_addr);
    chk("ldld_addr_sel", 32'(bus0.addr_fwd_sel), LDF ? 32'd1 : 32'd0);
    chk("ldld_fwd_addr", bus0.fwd_addr, LDF ? 32'h3000 : 32'h0);
    chk("ldld_data_sel", 32'(bus0.data_fwd_sel), 0);
    chk("ldld_stall", 32'(bus.hazard_stall), 0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
